// File: rtl/debug_dump_unit_pkg.sv
// Shared debug-dump definitions: FSM states, header tag, frame offsets, frame length helper.
// The frame length includes the trailing checksum word when DUMP_CHECKSUM_EN is defined.
package debug_dump_unit_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned IDX_W  = 11;

    localparam logic [15:0] HDR_TAG_DEFAULT = 16'hDEB0;

    localparam int unsigned OFF_HDR  = 0;
    localparam int unsigned OFF_PC   = 1;
    localparam int unsigned OFF_CYC  = 2;
    localparam int unsigned OFF_REGS = 3;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        LATCH     = 3'd2,
        SEND      = 3'd3,
        WAIT_ACK  = 3'd4,
        WAIT_DONE = 3'd5,
        FINISH    = 3'd6
    } state_t;

    function automatic int unsigned frame_words(input int unsigned n_regs, input int unsigned n_mem);
`ifdef DUMP_CHECKSUM_EN
        return OFF_REGS + n_regs + n_mem + 1;
`else
        return OFF_REGS + n_regs + n_mem;
`endif
    endfunction

endpackage

// File: rtl/debug_dump_unit_if.sv
// Debug dump bus: trigger/core inputs, register/memory read ports and the Tx word handshake.
interface debug_dump_unit_if;
    localparam int unsigned DW = 32;
    localparam int unsigned RW = 5;

    logic          start_dump;
    logic          mips_enable;
    logic [DW-1:0] pc;
    logic [RW-1:0] reg_addr;
    logic [DW-1:0] reg_data;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          tx_dataready;
    logic [DW-1:0] UART_data;
    logic          TX_start;
    logic          busy;
    logic          dump_done;

    modport master (
        input  start_dump, mips_enable, pc, reg_data, mem_data, tx_dataready,
        output reg_addr, mem_addr, UART_data, TX_start, busy, dump_done
    );

    modport slave (
        output start_dump, mips_enable, pc, reg_data, mem_data, tx_dataready,
        input  reg_addr, mem_addr, UART_data, TX_start, busy, dump_done
    );
endinterface

// File: rtl/debug_dump_unit_cycle_counter.sv
// Saturating 32-bit cycle counter, advancing only while the core is enabled.
module debug_cycle_counter
    import debug_dump_unit_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic [WORD_W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + WORD_W'(1);
        end
    end

endmodule

// File: rtl/debug_dump_unit.sv
// Serialises the debug frame (header, pc, cycle count, registers, memory window) to the Tx path.
// Optional trailing XOR checksum word under DUMP_CHECKSUM_EN.
module debug_dump_unit
    import debug_dump_unit_pkg::*;
#(
    parameter int unsigned        N_REGS   = 32,
    parameter int unsigned        N_MEM    = 16,
    parameter logic [WORD_W-1:0]  MEM_BASE = 32'h0000_0000,
    parameter logic [15:0]        HDR_TAG  = HDR_TAG_DEFAULT
)(
    input  logic              clk,
    input  logic              reset,
    debug_dump_unit_if.master bus
);

    localparam int unsigned    W         = frame_words(N_REGS, N_MEM);
    localparam logic [IDX_W-1:0] LAST      = IDX_W'(W - 1);
    localparam logic [IDX_W-1:0] IDX_HDR   = IDX_W'(OFF_HDR);
    localparam logic [IDX_W-1:0] IDX_PC    = IDX_W'(OFF_PC);
    localparam logic [IDX_W-1:0] IDX_CYC   = IDX_W'(OFF_CYC);
    localparam logic [IDX_W-1:0] REG_START = IDX_W'(OFF_REGS);
    localparam logic [IDX_W-1:0] REG_END   = IDX_W'(OFF_REGS + N_REGS);
    localparam logic [IDX_W-1:0] MEM_END   = IDX_W'(OFF_REGS + N_REGS + N_MEM);

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  k, k_nxt;
    logic [WORD_W-1:0] snap, snap_nxt;
    logic [WORD_W-1:0] uart_nxt, mem_addr_nxt, word, count;
    logic [4:0]        reg_addr_nxt;
    logic              tx_start_nxt, busy_nxt, done_nxt;
`ifdef DUMP_CHECKSUM_EN
    logic [WORD_W-1:0] csum, csum_nxt;
`endif

    debug_cycle_counter u_cycle_counter (
        .clk    (clk),
        .reset  (reset),
        .enable (bus.mips_enable),
        .count  (count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            k             <= '0;
            snap          <= '0;
            bus.UART_data <= '0;
            bus.TX_start  <= 1'b0;
            bus.busy      <= 1'b0;
            bus.dump_done <= 1'b0;
            bus.reg_addr  <= '0;
            bus.mem_addr  <= MEM_BASE;
`ifdef DUMP_CHECKSUM_EN
            csum          <= '0;
`endif
        end else begin
            state         <= state_nxt;
            k             <= k_nxt;
            snap          <= snap_nxt;
            bus.UART_data <= uart_nxt;
            bus.TX_start  <= tx_start_nxt;
            bus.busy      <= busy_nxt;
            bus.dump_done <= done_nxt;
            bus.reg_addr  <= reg_addr_nxt;
            bus.mem_addr  <= mem_addr_nxt;
`ifdef DUMP_CHECKSUM_EN
            csum          <= csum_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt    = state;
        k_nxt        = k;
        snap_nxt     = snap;
        uart_nxt     = bus.UART_data;
        tx_start_nxt = 1'b0;
        busy_nxt     = bus.busy;
        done_nxt     = 1'b0;
        reg_addr_nxt = bus.reg_addr;
        mem_addr_nxt = bus.mem_addr;
        word         = '0;
`ifdef DUMP_CHECKSUM_EN
        csum_nxt     = csum;
`endif

        case (state)
            IDLE: begin
                if (bus.start_dump) begin
                    snap_nxt  = count;
                    k_nxt     = '0;
                    busy_nxt  = 1'b1;
                    state_nxt = FETCH;
`ifdef DUMP_CHECKSUM_EN
                    csum_nxt  = '0;
`endif
                end
            end
            FETCH: state_nxt = LATCH;
            LATCH: begin
                if (k == IDX_HDR)      word = {HDR_TAG, 16'(W)};
                else if (k == IDX_PC)  word = bus.pc;
                else if (k == IDX_CYC) word = snap;
                else if (k < REG_END)  word = bus.reg_data;
                else                   word = bus.mem_data;
`ifdef DUMP_CHECKSUM_EN
                if (k == LAST) word = csum;
                else           csum_nxt = csum ^ word;
`endif
                uart_nxt  = word;
                state_nxt = SEND;
            end
            SEND: begin
                if (bus.tx_dataready) begin
                    tx_start_nxt = 1'b1;
                    state_nxt    = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (!bus.tx_dataready) state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (bus.tx_dataready) begin
                    if (k == LAST) begin
                        done_nxt  = 1'b1;
                        busy_nxt  = 1'b0;
                        state_nxt = FINISH;
                    end else begin
                        k_nxt     = k + IDX_W'(1);
                        state_nxt = FETCH;
                    end
                end
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // Addresses are presented for the whole FETCH cycle so a synchronous RAM answers in LATCH
        if (state_nxt == FETCH) begin
            if ((k_nxt >= REG_START) && (k_nxt < REG_END))
                reg_addr_nxt = 5'(k_nxt - REG_START);
            if ((k_nxt >= REG_END) && (k_nxt < MEM_END))
                mem_addr_nxt = MEM_BASE + WORD_W'({k_nxt - REG_END, 2'b00});
        end
    end

endmodule

// File: tb/tb_debug_dump_unit.sv
// Self-checking bench for debug_dump_unit: two instances, a Tx ready model and a frame reference model.
module tb_debug_dump_unit;

`ifdef DUMP_CHECKSUM_EN
    localparam int unsigned CS = 1;
`else
    localparam int unsigned CS = 0;
`endif
    localparam int unsigned NR0 = 32, NM0 = 16, NR1 = 4, NM1 = 0;
    localparam logic [31:0] MB1 = 32'h0000_0040;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    debug_dump_unit_if d0();
    debug_dump_unit_if d1();

    debug_dump_unit u_dut0 (.clk(clk), .reset(reset), .bus(d0));
    debug_dump_unit #(.N_REGS(NR1), .N_MEM(NM1), .MEM_BASE(MB1)) u_dut1 (.clk(clk), .reset(reset), .bus(d1));

    logic [31:0] rf [32];
    logic [31:0] dm [16];

    function automatic logic [31:0] dm_read(input logic [31:0] a, input logic [31:0] base);
        logic [31:0] idx;
        idx = (a - base) >> 2;
        return (idx < 32'd16) ? dm[idx[3:0]] : 32'hBAD0_BAD0;
    endfunction

    // synchronous-read register file and data memory
    always @(posedge clk) begin
        d0.reg_data <= rf[d0.reg_addr];
        d0.mem_data <= dm_read(d0.mem_addr, 32'h0);
        d1.reg_data <= rf[d1.reg_addr];
        d1.mem_data <= dm_read(d1.mem_addr, MB1);
    end

    // Tx model: drops ready on TX_start, raises it again after low_len cycles (0 = random)
    int unsigned low_len = 20;
    int unsigned low0, low1;
    always @(negedge clk or posedge reset) begin
        if (reset) begin
            d0.tx_dataready = 1'b1; low0 = 0;
            d1.tx_dataready = 1'b1; low1 = 0;
        end else begin
            if (d0.TX_start) begin
                d0.tx_dataready = 1'b0;
                low0 = (low_len == 0) ? $urandom_range(2, 20) : low_len;
            end else if (low0 > 0) begin
                low0--;
                if (low0 == 0) d0.tx_dataready = 1'b1;
            end
            if (d1.TX_start) begin
                d1.tx_dataready = 1'b0;
                low1 = (low_len == 0) ? $urandom_range(2, 20) : low_len;
            end else if (low1 > 0) begin
                low1--;
                if (low1 == 0) d1.tx_dataready = 1'b1;
            end
        end
    end

    logic [31:0] w0[$], w1[$];
    int done0, done1, done_at0, done_at1, busy_bad0, busy_bad1, mem_moved1;
    always @(negedge clk) begin
        if (!reset) begin
            if (d0.TX_start) begin w0.push_back(d0.UART_data); if (d0.busy !== 1'b1) busy_bad0++; end
            if (d0.dump_done) begin done0++; done_at0 = w0.size(); end
            if (d1.TX_start) begin w1.push_back(d1.UART_data); if (d1.busy !== 1'b1) busy_bad1++; end
            if (d1.dump_done) begin done1++; done_at1 = w1.size(); end
            if (d1.mem_addr !== MB1) mem_moved1++;
        end
    end

    // reference cycle count for instance 0: enabled posedges since reset, saturating
    logic [31:0] ref_cnt;
    always @(posedge clk or posedge reset) begin
        if (reset) ref_cnt = 32'd0;
        else if (d0.mips_enable === 1'b1 && ref_cnt != 32'hFFFF_FFFF) ref_cnt = ref_cnt + 32'd1;
    end

    int errors = 0, checks = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [31:0] exp_q[$];
    task automatic build_exp(input int unsigned nr, input int unsigned nm,
                             input logic [31:0] pcv, input logic [31:0] cyc);
        logic [31:0] x;
        exp_q.delete();
        exp_q.push_back({16'hDEB0, 16'(3 + nr + nm + CS)});
        exp_q.push_back(pcv);
        exp_q.push_back(cyc);
        for (int i = 0; i < int'(nr); i++) exp_q.push_back(rf[i]);
        for (int i = 0; i < int'(nm); i++) exp_q.push_back(dm[i]);
        if (CS != 0) begin
            x = 32'd0;
            foreach (exp_q[i]) x ^= exp_q[i];
            exp_q.push_back(x);
        end
    endtask

    task automatic cmp_frame(input string tag, input int which);
        int n;
        n = (which == 0) ? w0.size() : w1.size();
        check({tag, "_count"}, 32'(n), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < n; i++)
            check($sformatf("%s_w%0d", tag, i), (which == 0) ? w0[i] : w1[i], exp_q[i]);
    endtask

    task automatic clear_mon();
        w0.delete(); w1.delete();
        done0 = 0; done1 = 0; done_at0 = 0; done_at1 = 0;
        busy_bad0 = 0; busy_bad1 = 0; mem_moved1 = 0;
    endtask

    task automatic wait_done0(input string tag, input int bound, input bit rand_en);
        int c;
        c = 0;
        while (done0 == 0 && c < bound) begin
            @(negedge clk);
            c++;
            if (rand_en) d0.mips_enable = 1'($urandom);
        end
        check({tag, "_done_seen"}, 32'(done0 != 0), 32'd1);
    endtask

    logic [31:0] pcv, cyc;
    int c;
    bit p5, p50;

    initial begin
        reset = 1'b1;
        d0.start_dump = 1'b0; d0.mips_enable = 1'b0; d0.pc = 32'h0;
        d1.start_dump = 1'b0; d1.mips_enable = 1'b0; d1.pc = 32'h0;
        for (int i = 0; i < 32; i++) rf[i] = 32'(i) * 32'h0000_0101;
        for (int i = 0; i < 16; i++) dm[i] = 32'hA000_0000 + 32'(i);
        clear_mon();
        repeat (3) @(negedge clk);

        check("rst_uart", d0.UART_data, 32'h0);
        check("rst_txstart", 32'(d0.TX_start), 32'h0);
        check("rst_busy", 32'(d0.busy), 32'h0);
        check("rst_done", 32'(d0.dump_done), 32'h0);
        check("rst_regaddr", 32'(d0.reg_addr), 32'h0);
        check("rst_memaddr", d0.mem_addr, 32'h0);
        check("rst_memaddr1", d1.mem_addr, MB1);

        reset = 1'b0;
        @(negedge clk);

        // Frame A: 1000 enabled cycles, then dump with fixed data and spurious triggers
        d0.mips_enable = 1'b1;
        repeat (1000) @(negedge clk);
        pcv = $urandom;
        d0.pc = pcv;
        cyc = ref_cnt;
        d0.start_dump = 1'b1;
        c = 0; p5 = 0; p50 = 0;
        while (done0 == 0 && c < 8000) begin
            @(negedge clk);
            c++;
            d0.start_dump = 1'b0;
            if (!p5 && w0.size() >= 5)   begin d0.start_dump = 1'b1; p5 = 1; end
            if (!p50 && w0.size() >= 50) begin d0.start_dump = 1'b1; p50 = 1; end
        end
        d0.start_dump = 1'b0;
        check("A_done_seen", 32'(done0 != 0), 32'd1);
        check("A_hdr", (w0.size() > 0) ? w0[0] : 32'hFFFF_FFFF, {16'hDEB0, 16'(51 + CS)});
        check("A_cyc1000", (w0.size() > 2) ? w0[2] : 32'hFFFF_FFFF, 32'd1000);
        build_exp(NR0, NM0, pcv, cyc);
        cmp_frame("A", 0);
        check("A_done_after_last", 32'(done_at0), 32'(51 + CS));
        check("A_busy_bad", 32'(busy_bad0), 32'd0);
        repeat (40) @(negedge clk);
        check("A_no_requeue_words", 32'(w0.size()), 32'(51 + CS));
        check("A_done_once", 32'(done0), 32'd1);
        check("A_idle_busy", 32'(d0.busy), 32'd0);

        // Frame B: random data, random Tx window, enable toggling during the dump
        clear_mon();
        low_len = 0;
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        for (int i = 0; i < 16; i++) dm[i] = $urandom;
        pcv = $urandom;
        d0.pc = pcv;
        cyc = ref_cnt;
        d0.start_dump = 1'b1;
        @(negedge clk);
        d0.start_dump = 1'b0;
        wait_done0("B", 8000, 1'b1);
        build_exp(NR0, NM0, pcv, cyc);
        cmp_frame("B", 0);
        check("B_done_once", 32'(done0), 32'd1);

        // Frame C: reset while waiting for word 10 to finish, then a fresh frame
        clear_mon();
        low_len = 20;
        d0.mips_enable = 1'b0;
        d0.start_dump = 1'b1;
        @(negedge clk);
        d0.start_dump = 1'b0;
        c = 0;
        while (w0.size() < 10 && c < 4000) begin @(negedge clk); c++; end
        check("C_reached_w10", 32'(w0.size() >= 10), 32'd1);
        repeat (3) @(negedge clk);
        check("C_busy_before_rst", 32'(d0.busy), 32'd1);
        reset = 1'b1;
        #1;
        check("C_rst_txstart", 32'(d0.TX_start), 32'd0);
        check("C_rst_busy", 32'(d0.busy), 32'd0);
        check("C_rst_uart", d0.UART_data, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        clear_mon();
        low_len = 0;
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        d0.mips_enable = 1'b1;
        repeat ($urandom_range(5, 40)) @(negedge clk);
        pcv = $urandom;
        d0.pc = pcv;
        cyc = ref_cnt;
        d0.start_dump = 1'b1;
        @(negedge clk);
        d0.start_dump = 1'b0;
        wait_done0("C2", 8000, 1'b0);
        build_exp(NR0, NM0, pcv, cyc);
        cmp_frame("C2", 0);

        // Frame D: small instance without memory window
        clear_mon();
        pcv = $urandom;
        d1.pc = pcv;
        d1.start_dump = 1'b1;
        @(negedge clk);
        d1.start_dump = 1'b0;
        c = 0;
        while (done1 == 0 && c < 2000) begin @(negedge clk); c++; end
        check("D_done_seen", 32'(done1 != 0), 32'd1);
        check("D_hdr", (w1.size() > 0) ? w1[0] : 32'hFFFF_FFFF, {16'hDEB0, 16'(7 + CS)});
        build_exp(NR1, NM1, pcv, 32'd0);
        cmp_frame("D", 1);
        check("D_memaddr_moved", 32'(mem_moved1), 32'd0);
        check("D_done_after_last", 32'(done_at1), 32'(7 + CS));
        check("D_busy_bad", 32'(busy_bad1), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
